channel_scale_broadcast: RTL
============================

Name: channel_scale_broadcast

Overview:
- Expand-side counterpart of the global average pool in the squeeze-excitation path.
- Captures one scale value per channel, arriving as a per-channel stream in channel order, the same format the pool emits.
- Then accepts the full feature map (channel-major, IN_HEIGHT*IN_WIDTH pixels per channel) and multiplies every pixel by its channel's scale.
- Emits the rescaled feature stream with fixed single-cycle latency.

Parameters:
DATA_WIDTH, 16, unsigned feature pixel width (input and output)
SCALE_WIDTH, 8, unsigned scale width
SCALE_FRAC, 7, fractional bits of scale (1.0 = 2^SCALE_FRAC)
IN_HEIGHT, 8, feature map height
IN_WIDTH, 8, feature map width
CHANNELS, 16, channel count

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
scale_in  input  SCALE_WIDTH  per-channel scale, channel 0 first
scale_valid  input  1  scale_in valid; no backpressure
feat_in  input  DATA_WIDTH  feature pixel, channel-major
feat_valid  input  1  feat_in valid
feat_ready  output  1  block accepts feat_in this cycle
out_data  output  DATA_WIDTH  rescaled pixel
out_valid  output  1  out_data valid
frame_done  output  1  one-cycle pulse with the last output pixel of a frame
busy  output  1  high in STREAM state
err_overrun  output  1  sticky: scale_valid seen while in STREAM

Behaviour:
- Interface decision: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: out_data=0, out_valid=0, frame_done=0, err_overrun=0, feat_ready=0, busy=0. State=LOAD, all counters=0, scale buffer cleared to 0.
- Reset mid-frame discards everything, including partially loaded scales and the in-flight output.

State LOAD:
- feat_ready=0.
- Each cycle with scale_valid=1: store scale_in into buf[scale_cnt], then scale_cnt++.
- Gaps in scale_valid are allowed.
- When the store is for index CHANNELS-1: scale_cnt returns to 0 and the next state is STREAM.

State STREAM:
- feat_ready=1 and busy=1. Accept occurs when feat_valid && feat_ready.
- Counters: pix_cnt runs 0..IN_HEIGHT*IN_WIDTH-1. On wrap, pix_cnt returns to 0 and ch_cnt++.
- On accept of pix_cnt=last and ch_cnt=CHANNELS-1: counters clear and the next state is LOAD (feat_ready drops the following cycle).
- scale_valid in STREAM: value ignored and err_overrun set. err_overrun is cleared only by reset.

Handoff between frames:
- A scale_valid in the cycle after the last feature accept belongs to the next frame and is stored normally.

Arithmetic, registered once:
- prod = feat_in * buf[ch_cnt], full width DATA_WIDTH+SCALE_WIDTH.
- rnd = (prod + 2^(SCALE_FRAC-1)) >> SCALE_FRAC, i.e. round half up.
- If rnd > 2^DATA_WIDTH-1, out_data = 2^DATA_WIDTH-1 (saturate); otherwise out_data = rnd.

Output timing:
- out_valid=1 exactly one cycle after each accept; 0 otherwise.
- out_data holds its last value when out_valid=0.
- frame_done=1 in the same cycle as out_valid for the final pixel of the final channel.
- No output backpressure: the downstream stage must absorb one pixel per cycle.

Throughput:
- One pixel per cycle in STREAM.
- Frame period is CHANNELS scale cycles plus CHANNELS*IN_HEIGHT*IN_WIDTH feature cycles, with no dead cycles required between frames.

Test Plan:
- Basic (CHANNELS=2, IN_HEIGHT=IN_WIDTH=2): load scales 128, 64, then feed features 10,20,30,40,100,3,7,8 -> outputs 10,20,30,40,50,2,4,4, each one cycle after its accept. frame_done pulses with the 8th output; busy falls the following cycle.
- Saturation: scale 255, feature 65535 -> out_data=65535. Scale 0, feature 65535 -> out_data=0.
- Gaps and flow control: scale_valid with idle cycles and feat_valid toggling randomly -> outputs match the golden model in order. feat_ready=0 throughout LOAD, and features offered in LOAD are not consumed.
- Back-to-back frames: second-frame scales start in the cycle after the last feature accept -> second frame uses the new scales, with no frame_done glitch and err_overrun=0.
- Overrun: scale_valid pulsed mid-STREAM -> err_overrun=1 and stays 1. Current frame outputs unchanged, using the original scales.
- Reset mid-STREAM (after 3 accepts) -> out_valid, frame_done, busy and feat_ready drop immediately. Block returns to LOAD, and a fresh full frame then processes correctly.

Source files
------------

// File: rtl/channel_scale_broadcast.sv
// channel_scale_broadcast: expand side of the squeeze-excitation path.
// Loads one unsigned scale per channel, then multiplies every pixel of the
// channel-major feature map by its channel's scale with round-half-up and
// saturation. Output is registered once: one cycle after each accept.
module channel_scale_broadcast #(
    parameter int DATA_WIDTH  = 16,
    parameter int SCALE_WIDTH = 8,
    parameter int SCALE_FRAC  = 7,
    parameter int IN_HEIGHT   = 8,
    parameter int IN_WIDTH    = 8,
    parameter int CHANNELS    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SCALE_WIDTH-1:0] scale_in,
    input  logic                   scale_valid,
    input  logic [DATA_WIDTH-1:0]  feat_in,
    input  logic                   feat_valid,
    output logic                   feat_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    output logic                   frame_done,
    output logic                   busy,
    output logic                   err_overrun
);

    localparam int PIX    = IN_HEIGHT * IN_WIDTH;
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PIX_W  = (PIX > 1) ? $clog2(PIX) : 1;
    localparam int PROD_W = DATA_WIDTH + SCALE_WIDTH;

    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(CHANNELS - 1);
    localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(PIX - 1);
    localparam logic [PROD_W:0]   HALF     = (PROD_W + 1)'(1) << (SCALE_FRAC - 1);
    localparam logic [PROD_W:0]   SAT_MAX  = (PROD_W + 1)'({DATA_WIDTH{1'b1}});

    typedef enum logic {
        LOAD   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t state_q, next_state;

    logic [SCALE_WIDTH-1:0] scale_buf [CHANNELS];
    logic [CH_W-1:0]        scale_cnt;
    logic [CH_W-1:0]        ch_cnt;
    logic [PIX_W-1:0]       pix_cnt;

    logic                   in_stream;
    logic                   scale_store;
    logic                   accept;
    logic                   last_scale;
    logic                   last_pix;
    logic                   frame_end;

    logic [PROD_W-1:0]      prod_p0;
    logic [DATA_WIDTH-1:0]  res_p0;

    logic [DATA_WIDTH-1:0]  out_data_p1;
    logic                   vld_p1;
    logic                   done_p1;

    // Round half up by adding 2^(SCALE_FRAC-1) before the shift, then clamp
    // to the largest representable pixel.
    function automatic logic [DATA_WIDTH-1:0] round_sat(input logic [PROD_W-1:0] prod);
        logic [PROD_W:0] sum;
        logic [PROD_W:0] rnd;
        sum = {1'b0, prod} + HALF;
        rnd = sum >> SCALE_FRAC;
        if (rnd > SAT_MAX) begin
            round_sat = '1;
        end else begin
            round_sat = rnd[DATA_WIDTH-1:0];
        end
    endfunction

    assign in_stream   = (state_q == STREAM);
    assign feat_ready  = in_stream;
    assign busy        = in_stream;
    assign scale_store = scale_valid && !in_stream;
    assign accept      = feat_valid && in_stream;
    assign last_scale  = (scale_cnt == CH_LAST);
    assign last_pix    = (pix_cnt == PIX_LAST);
    assign frame_end   = accept && last_pix && (ch_cnt == CH_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= next_state;
        end
    end

    // Next state: leave LOAD on the last scale, leave STREAM on the last pixel.
    always_comb begin
        next_state = state_q;
        case (state_q)
            LOAD:    if (scale_store && last_scale) next_state = STREAM;
            STREAM:  if (frame_end) next_state = LOAD;
            default: next_state = LOAD;
        endcase
    end

    // Scale buffer fill; a partially loaded buffer is discarded by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                scale_buf[i] <= '0;
            end
            scale_cnt <= '0;
        end else if (scale_store) begin
            scale_buf[scale_cnt] <= scale_in;
            scale_cnt            <= last_scale ? '0 : scale_cnt + 1'b1;
        end
    end

    // Pixel and channel position within the frame, advanced per accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt <= '0;
            ch_cnt  <= '0;
        end else if (accept) begin
            if (last_pix) begin
                pix_cnt <= '0;
                ch_cnt  <= (ch_cnt == CH_LAST) ? '0 : ch_cnt + 1'b1;
            end else begin
                pix_cnt <= pix_cnt + 1'b1;
            end
        end
    end

    // Overrun flag: a scale arriving while streaming is dropped and remembered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_overrun <= 1'b0;
        end else if (scale_valid && in_stream) begin
            err_overrun <= 1'b1;
        end
    end

    // ---- stage p0: multiply by the current channel's scale, round, saturate
    assign prod_p0 = PROD_W'(feat_in) * PROD_W'(scale_buf[ch_cnt]);
    assign res_p0  = round_sat(prod_p0);

    // ---- stage p1: registered result; data holds between accepts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_p1 <= '0;
            vld_p1      <= 1'b0;
            done_p1     <= 1'b0;
        end else begin
            vld_p1  <= accept;
            done_p1 <= frame_end;
            if (accept) begin
                out_data_p1 <= res_p0;
            end
        end
    end

    assign out_data   = out_data_p1;
    assign out_valid  = vld_p1;
    assign frame_done = done_p1;

endmodule
